// File: rtl/stack_cmd_ctrl.sv
// Valid/ready command front-end for an SRAM stack: occupancy tracking,
// overflow/underflow rejection, strobe generation and data-bus tristate control.
module stack_cmd_ctrl #(
  parameter int DEPTH = 1024,
  parameter int CW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic          cmd_op,
  input  logic [7:0]    cmd_data,
  output logic          cmd_ready,
  output logic          rsp_valid,
  output logic [7:0]    rsp_data,
  output logic          rsp_err,
  input  logic          rsp_ready,
  inout  wire  [7:0]    stk_data,
  output logic          stk_enable,
  output logic          stk_push_pop,
  input  logic          stk_empty,
  input  logic          stk_full,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_e;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Either the local count or the stack's own flag is enough to reject.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op) begin
            if (count_q == FULL_CNT || stk_full) begin
              state_d    = RESP;
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
            end else begin
              wdata_d = cmd_data;
              state_d = WR;
            end
          end else begin
            if (count_q == '0 || stk_empty) begin
              state_d    = RESP;
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      WR: begin
        count_d    = count_q + CW'(1);
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
        state_d    = RESP;
      end
      RD: begin
        count_d    = count_q - CW'(1);
        rsp_err_d  = 1'b0;
        rsp_data_d = stk_data;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign stk_enable   = (state_q == WR) || (state_q == RD);
  assign stk_push_pop = (state_q == WR);
  assign stk_data     = (state_q == WR) ? wdata_q : 8'hzz;
  assign count        = count_q;

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Directed bench for stack_cmd_ctrl with a behavioural 1024x8 stack on the bus.
module tb_stack_cmd_ctrl;
  localparam int DEPTH = 1024;
  localparam int CW    = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_op = 1'b0;
  logic [7:0]    cmd_data = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_err;
  logic          rsp_ready = 1'b1;
  wire  [7:0]    stk_data;
  logic          stk_enable;
  logic          stk_push_pop;
  logic          stk_empty;
  logic          stk_full;
  logic [CW-1:0] count;

  int n_chk  = 0;
  int n_fail = 0;

  // stack model plus a bench-side probe driver for checking bus release
  logic [7:0] mem [0:DEPTH-1];
  int         sp;
  logic [7:0] top;
  logic       full_ovr = 1'b0, empty_ovr = 1'b0;
  logic       probe_en = 1'b0;
  logic [7:0] probe_val = 8'h5A;

  always_comb top = (sp > 0 && sp <= DEPTH) ? mem[sp-1] : 8'h00;
  assign stk_data  = (stk_enable && !stk_push_pop) ? top : (probe_en ? probe_val : 8'hzz);
  assign stk_empty = (sp == 0) || empty_ovr;
  assign stk_full  = (sp == DEPTH) || full_ovr;

  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (stk_enable) begin
      if (stk_push_pop) begin
        if (sp < DEPTH) begin mem[sp] <= stk_data; sp <= sp + 1; end
      end else if (sp > 0) sp <= sp - 1;
    end
  end

  always #5 clk = ~clk;

  stack_cmd_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .stk_data(stk_data), .stk_enable(stk_enable),
    .stk_push_pop(stk_push_pop), .stk_empty(stk_empty), .stk_full(stk_full), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_released(input string tag);
    probe_en = 1'b1;
    #1;
    chk(tag, {24'h0, stk_data}, {24'h0, probe_val});
    probe_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one command (rsp_ready high) and observe it through to its response.
  // lat = edges after acceptance until rsp_valid; en = cycles with stk_enable.
  task automatic send(input logic op, input logic [7:0] d,
                      output int lat, output int en, output logic pp,
                      output logic [7:0] bus, output logic [7:0] rd, output logic re);
    int k;
    k = 0;
    while (!cmd_ready && k < 10) begin @(negedge clk); k++; end
    chk("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; en = 0; pp = 1'b0; bus = 8'h00;
    while (!rsp_valid && lat < 4) begin
      if (stk_enable) begin en++; pp = stk_push_pop; bus = stk_data; end
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid_wait", {31'h0, rsp_valid}, 32'h1);
    rd = rsp_data;
    re = rsp_err;
  endtask

  initial begin
    int lat, en, nerr;
    logic pp, re;
    logic [7:0] bus, rd;

    do_reset();
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", {24'h0, rsp_data}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_stk_enable", {31'h0, stk_enable}, 32'h0);
    chk("rst_stk_push_pop", {31'h0, stk_push_pop}, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    bus_released("rst_bus_hiz");

    // single push
    send(1'b1, 8'hA5, lat, en, pp, bus, rd, re);
    chk("pushA5_lat", lat, 1);
    chk("pushA5_en", en, 1);
    chk("pushA5_pp", {31'h0, pp}, 32'h1);
    chk("pushA5_bus", {24'h0, bus}, 32'hA5);
    chk("pushA5_err", {31'h0, re}, 32'h0);
    chk("pushA5_data", {24'h0, rd}, 32'h0);
    chk("pushA5_count", 32'(count), 32'h1);
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("popA5_data", {24'h0, rd}, 32'hA5);
    chk("popA5_pp", {31'h0, pp}, 32'h0);
    chk("popA5_count", 32'(count), 32'h0);

    // LIFO ordering
    send(1'b1, 8'h11, lat, en, pp, bus, rd, re);
    send(1'b1, 8'h22, lat, en, pp, bus, rd, re);
    send(1'b1, 8'h33, lat, en, pp, bus, rd, re);
    chk("lifo_count3", 32'(count), 32'h3);
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("pop1_data", {24'h0, rd}, 32'h33);
    chk("pop1_err", {31'h0, re}, 32'h0);
    chk("pop1_count", 32'(count), 32'h2);
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("pop2_data", {24'h0, rd}, 32'h22);
    chk("pop2_count", 32'(count), 32'h1);
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("pop3_data", {24'h0, rd}, 32'h11);
    chk("pop3_en", en, 1);
    chk("pop3_count", 32'(count), 32'h0);

    // underflow
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("uflow_lat", lat, 0);
    chk("uflow_en", en, 0);
    chk("uflow_err", {31'h0, re}, 32'h1);
    chk("uflow_data", {24'h0, rd}, 32'h0);
    chk("uflow_count", 32'(count), 32'h0);

    // stack flags alone force a reject
    full_ovr = 1'b1;
    send(1'b1, 8'h44, lat, en, pp, bus, rd, re);
    full_ovr = 1'b0;
    chk("fullflag_err", {31'h0, re}, 32'h1);
    chk("fullflag_en", en, 0);
    chk("fullflag_count", 32'(count), 32'h0);
    send(1'b1, 8'h55, lat, en, pp, bus, rd, re);
    empty_ovr = 1'b1;
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    empty_ovr = 1'b0;
    chk("emptyflag_err", {31'h0, re}, 32'h1);
    chk("emptyflag_en", en, 0);
    chk("emptyflag_count", 32'(count), 32'h1);
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("emptyflag_pop", {24'h0, rd}, 32'h55);

    // fill to capacity, then overflow
    nerr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b1, 8'(i) ^ 8'h3C, lat, en, pp, bus, rd, re);
      if (re) nerr++;
    end
    chk("fill_errs", nerr, 0);
    chk("fill_count", 32'(count), 32'd1024);
    send(1'b1, 8'hEE, lat, en, pp, bus, rd, re);
    chk("oflow_err", {31'h0, re}, 32'h1);
    chk("oflow_en", en, 0);
    chk("oflow_lat", lat, 0);
    chk("oflow_count", 32'(count), 32'd1024);
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("full_pop_data", {24'h0, rd}, 32'hC3);
    chk("full_pop_count", 32'(count), 32'd1023);

    // response back-pressure
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_rd_en", {31'h0, stk_enable}, 32'h1);
    chk("bp_rd_pp", {31'h0, stk_push_pop}, 32'h0);
    @(negedge clk);
    chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("bp_rsp_data", {24'h0, rsp_data}, 32'hC2);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 8'h77;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_data", {24'h0, rsp_data}, 32'hC2);
      chk("hold_err", {31'h0, rsp_err}, 32'h0);
      chk("hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("hold_en", {31'h0, stk_enable}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rel_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rel_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rel_en", {31'h0, stk_enable}, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rel_wr_en", {31'h0, stk_enable}, 32'h1);
    chk("rel_wr_pp", {31'h0, stk_push_pop}, 32'h1);
    chk("rel_wr_bus", {24'h0, stk_data}, 32'h77);
    @(negedge clk);
    chk("rel_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("rel_count", 32'(count), 32'd1023);
    @(negedge clk);

    // reset in the middle of a write
    do_reset();
    for (int i = 1; i <= 5; i++) send(1'b1, 8'(i), lat, en, pp, bus, rd, re);
    chk("mid_count5", 32'(count), 32'h5);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_wr_en", {31'h0, stk_enable}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_count", 32'(count), 32'h0);
    chk("mid_en", {31'h0, stk_enable}, 32'h0);
    chk("mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    bus_released("mid_bus_hiz");
    rst = 1'b0;
    send(1'b0, 8'h00, lat, en, pp, bus, rd, re);
    chk("post_rst_pop_err", {31'h0, re}, 32'h1);
    chk("post_rst_pop_en", en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
